uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling UART receiver, the counterpart of the UART transmit path. It recovers start, data, optional parity and stop bits from the serial line. The received byte is presented on a parallel bus with a one-cycle valid strobe, and framing and parity errors are flagged. It sits between the top-level RX synchroniser and the parallel data consumer (register file or FIFO).

## Interface
- DATA_WIDTH, 8: data bits per frame.
- clk  input  1  system clock; all logic on rising edge.
- RST  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line; already synchronous to clk; idle high.
- Prescale  input  6  clk cycles per bit; legal values are 8, 16, 32; any other value gives undefined behaviour; must be stable while not in IDLE.
- PAR_EN  input  1  1 means a parity bit follows the data; sampled at start detection.
- PAR_TYP  input  1  0 means even parity, 1 means odd parity; sampled at start detection.
- P_DATA  output  DATA_WIDTH  last good byte; LSB is the first received bit.
- Data_Valid  output  1  one-cycle pulse when P_DATA holds a new error-free byte.
- parity_error  output  1  one-cycle pulse when the frame's parity mismatches.
- stop_error  output  1  one-cycle pulse when the frame's stop bit is sampled 0.

## Operation
- States are IDLE, START, DATA, PARITY, STOP.
- edge_cnt counts 0..Prescale-1 within each bit. bit_cnt counts 0..DATA_WIDTH-1 in DATA.
- Sampling: take RX_IN at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1. The bit value is the 2-of-3 majority, registered and valid from edge_cnt = Prescale/2+2.
- IDLE: edge_cnt is held at 0. If RX_IN = 0 this cycle, go to START with edge_cnt = 1; this cycle is sample index 0 of the start bit. PAR_EN and PAR_TYP are latched in the same cycle.
- START: at edge_cnt = Prescale-1, a sampled 1 means a glitch: return to IDLE with no outputs. A sampled 0 goes to DATA.
- DATA: at each bit end, shift the sampled bit into the MSB of the shift register, so the register ends LSB-first. After bit DATA_WIDTH-1, go to PARITY if the latched PAR_EN is 1, else go to STOP.
- PARITY: expected parity is the XOR of the data bits, inverted when PAR_TYP = 1. Record a mismatch at the end of the bit, then go to STOP.
- STOP: at edge_cnt = Prescale-1, go to IDLE. In the same edge, register the frame result:
  - Data_Valid = 1 if there is no parity mismatch and the stop sample is 1. P_DATA is loaded only on this condition.
  - parity_error = 1 if a parity mismatch was recorded.
  - stop_error = 1 if the stop sample is 0.
  - Both errors can pulse in the same cycle. Data_Valid never pulses together with an error.
- All three strobes are high for exactly one cycle. P_DATA holds its value until the next good frame.
- Back-to-back frames: IDLE is entered exactly at the stop-bit end, so a start bit immediately after the stop bit is detected with zero slip.
- A Prescale change while not in IDLE is illegal; the bench must not do it.

## Timing
- Reset values: all outputs are 0, state is IDLE, and the counters and shift register are 0. Reset takes effect immediately and asynchronously.
- Reset mid-frame: the partial frame is discarded, no strobes are produced, and reception resumes from IDLE after release.
- Frame length N = 1 + DATA_WIDTH + PAR_EN + 1 bits.
- Let cycle 0 be the cycle in which IDLE samples RX_IN = 0. The strobes are high in cycle N·Prescale.
  - Prescale = 8, no parity: cycle 80.
  - Prescale = 8, with parity: cycle 88.
- Glitch abort: the state is IDLE again at cycle Prescale, and a new start can be detected in that cycle.

## Structure
- Package uart_pkg holds:
  - state encoding localparams (IDLE = 3'b000, START = 3'b001, DATA = 3'b010, PARITY = 3'b011, STOP = 3'b100), shared with the TX FSM;
  - parity-type constants PAR_EVEN = 1'b0 and PAR_ODD = 1'b1.
- One sub-module, uart_rx_sampler, contains the edge counter, the 3-point majority sampler and a bit_end strobe.
- The FSM, deserializer and parity/stop checks stay in uart_rx.

## Test plan
- Prescale = 8, PAR_EN = 0, frame 0xA5 → P_DATA = 0xA5 and Data_Valid high at cycle 80 only; no error strobes.
- Prescale = 16, PAR_EN = 1, PAR_TYP = 0, byte 0xA5 with parity bit 0 → Data_Valid at cycle 176. Repeat with parity bit 1 → parity_error pulse only, Data_Valid stays 0, P_DATA unchanged.
- Prescale = 8, RX_IN low for cycles 0-2 then high → no strobes, state IDLE at cycle 8. Next a valid 0x3C frame → P_DATA = 0x3C.
- Prescale = 32, PAR_EN = 0, byte 0x81 with stop bit 0 → stop_error pulse at cycle 320, Data_Valid stays 0.
- Prescale = 16, back-to-back frames 0x00 then 0xFF with no idle gap → two Data_Valid pulses 160 cycles apart, P_DATA = 0x00 then 0xFF.
- Reset asserted at cycle 40 of a Prescale = 8 frame → outputs go to 0 at once and no strobe appears. After release, a frame 0x5A → P_DATA = 0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings common to the RX and TX paths,
// parity-type constants and small combinational helpers.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'b000;
  localparam logic [2:0] START  = 3'b001;
  localparam logic [2:0] DATA   = 3'b010;
  localparam logic [2:0] PARITY = 3'b011;
  localparam logic [2:0] STOP   = 3'b100;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_START  = START,
    ST_DATA   = DATA,
    ST_PARITY = PARITY,
    ST_STOP   = STOP
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with a 3-point majority sampler around mid-bit and a
// bit_end strobe on the last clock of each bit.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       RST,
  input  logic       run,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  output logic       sampled_bit,
  output logic       bit_end
);

  logic [5:0] edge_cnt_r;
  logic [5:0] half_s;
  logic       samp0_r;
  logic       samp1_r;
  logic       sampled_bit_r;

  assign half_s      = {1'b0, prescale[5:1]};
  assign bit_end     = run && (edge_cnt_r == (prescale - 6'd1));
  assign sampled_bit = sampled_bit_r;

  // Edge counter: held at zero while idle, wraps at the end of every bit.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      edge_cnt_r <= 6'd0;
    end else if (!run || bit_end) begin
      edge_cnt_r <= 6'd0;
    end else begin
      edge_cnt_r <= edge_cnt_r + 6'd1;
    end
  end

  // Capture the first two mid-bit samples; the vote lands on the third.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      samp0_r       <= 1'b0;
      samp1_r       <= 1'b0;
      sampled_bit_r <= 1'b0;
    end else begin
      if (edge_cnt_r == (half_s - 6'd1)) samp0_r <= rx_in;
      if (edge_cnt_r == half_s)          samp1_r <= rx_in;
      if (edge_cnt_r == (half_s + 6'd1)) sampled_bit_r <= majority3(samp0_r, samp1_r, rx_in);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, LSB-first deserializer, parity and stop checks,
// with registered result strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  rx_state_e             state_r, state_next_s;
  logic [BW-1:0]         bit_cnt_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] p_data_r;
  logic                  par_en_r, par_typ_r, par_mis_r;
  logic                  data_valid_r, parity_error_r, stop_error_r;
  logic                  run_s, sampled_s, bit_end_s, start_det_s;

  function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] d, input logic typ);
    return (^d) ^ (typ == PAR_ODD);
  endfunction

  assign start_det_s = (state_r == ST_IDLE) && !RX_IN;
  assign run_s       = (state_r != ST_IDLE) || !RX_IN;

  uart_rx_sampler u_sampler (
    .clk         (clk),
    .RST         (RST),
    .run         (run_s),
    .rx_in       (RX_IN),
    .prescale    (Prescale),
    .sampled_bit (sampled_s),
    .bit_end     (bit_end_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state_r <= ST_IDLE;
    else      state_r <= state_next_s;
  end

  // Next-state decode; transitions happen only on bit boundaries after START.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:   if (!RX_IN) state_next_s = ST_START; else state_next_s = ST_IDLE;
      ST_START:  if (bit_end_s) state_next_s = sampled_s ? ST_IDLE : ST_DATA;
                 else state_next_s = ST_START;
      ST_DATA:   if (bit_end_s && (bit_cnt_r == LAST_BIT))
                   state_next_s = par_en_r ? ST_PARITY : ST_STOP;
                 else state_next_s = ST_DATA;
      ST_PARITY: if (bit_end_s) state_next_s = ST_STOP; else state_next_s = ST_PARITY;
      ST_STOP:   if (bit_end_s) state_next_s = ST_IDLE; else state_next_s = ST_STOP;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Deserializer, parity tracking and frame result strobes.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      bit_cnt_r      <= '0;
      shift_r        <= '0;
      p_data_r       <= '0;
      par_en_r       <= 1'b0;
      par_typ_r      <= 1'b0;
      par_mis_r      <= 1'b0;
      data_valid_r   <= 1'b0;
      parity_error_r <= 1'b0;
      stop_error_r   <= 1'b0;
    end else begin
      data_valid_r   <= 1'b0;
      parity_error_r <= 1'b0;
      stop_error_r   <= 1'b0;
      if (start_det_s) begin
        par_en_r  <= PAR_EN;
        par_typ_r <= PAR_TYP;
        par_mis_r <= 1'b0;
        bit_cnt_r <= '0;
      end
      if (bit_end_s) begin
        case (state_r)
          ST_DATA: begin
            shift_r   <= {sampled_s, shift_r[DATA_WIDTH-1:1]};
            bit_cnt_r <= (bit_cnt_r == LAST_BIT) ? '0 : bit_cnt_r + BW'(1);
          end
          ST_PARITY: par_mis_r <= (expected_parity(shift_r, par_typ_r) != sampled_s);
          ST_STOP: begin
            data_valid_r   <= !par_mis_r && sampled_s;
            parity_error_r <= par_mis_r;
            stop_error_r   <= !sampled_s;
            if (!par_mis_r && sampled_s) p_data_r <= shift_r;
          end
          default: ;
        endcase
      end
    end
  end

  assign P_DATA       = p_data_r;
  assign Data_Valid   = data_valid_r;
  assign parity_error = parity_error_r;
  assign stop_error   = stop_error_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives framed serial bits and checks strobe timing,
// received data and error flags against hand-computed expectations.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       Data_Valid, parity_error, stop_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0;
  int dv_t[$];
  int pe_t[$];
  int se_t[$];
  logic [7:0] dv_d[$];

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk(clk), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
    .Data_Valid(Data_Valid), .parity_error(parity_error), .stop_error(stop_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (Data_Valid) begin dv_t.push_back(cyc); dv_d.push_back(P_DATA); end
    if (parity_error) pe_t.push_back(cyc);
    if (stop_error) se_t.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    dv_t.delete(); dv_d.delete(); pe_t.delete(); se_t.delete();
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive nbits of a frame (LSB first), each held for p cycles.
  task automatic send_bits(input logic [11:0] bits, input int nbits, input int p);
    for (int i = 0; i < nbits; i++) begin
      RX_IN = bits[i];
      repeat (p) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop, input int p);
    logic [11:0] f;
    f = 12'hFFF;
    f[0] = 1'b0;
    f[8:1] = d;
    if (pen) begin f[9] = pbit; f[10] = stop; send_bits(f, 11, p); end
    else begin f[9] = stop; send_bits(f, 10, p); end
  endtask

  initial begin
    #12;
    chk("rst_pdata", {24'd0, P_DATA}, 32'h00);
    chk("rst_dv", {31'd0, Data_Valid}, 32'd0);
    chk("rst_pe", {31'd0, parity_error}, 32'd0);
    chk("rst_se", {31'd0, stop_error}, 32'd0);
    chk("rst_state", {29'd0, dut.state_r}, 32'd0);
    @(negedge clk); RST = 1'b1;
    @(posedge clk); #1;
    idle(4);

    // P=8, no parity, 0xA5
    clear_q(); Prescale = 6'd8; PAR_EN = 1'b0; t0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8); idle(6);
    chk("t1_dv_cnt", dv_t.size(), 32'd1);
    if (dv_t.size() > 0) begin
      chk("t1_dv_cyc", dv_t[0] - t0, 32'd80);
      chk("t1_dv_data", {24'd0, dv_d[0]}, 32'hA5);
    end
    chk("t1_err_cnt", pe_t.size() + se_t.size(), 32'd0);
    chk("t1_pdata", {24'd0, P_DATA}, 32'hA5);

    // P=16, even parity, good parity bit 0
    clear_q(); Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0; t0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 16); idle(6);
    chk("t2_dv_cnt", dv_t.size(), 32'd1);
    if (dv_t.size() > 0) chk("t2_dv_cyc", dv_t[0] - t0, 32'd176);
    chk("t2_pe_cnt", pe_t.size(), 32'd0);

    // same frame with wrong parity bit
    clear_q(); t0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 16); idle(6);
    chk("t3_pe_cnt", pe_t.size(), 32'd1);
    if (pe_t.size() > 0) chk("t3_pe_cyc", pe_t[0] - t0, 32'd176);
    chk("t3_dv_cnt", dv_t.size(), 32'd0);
    chk("t3_se_cnt", se_t.size(), 32'd0);
    chk("t3_pdata", {24'd0, P_DATA}, 32'hA5);

    // glitch on start bit, then valid 0x3C
    clear_q(); Prescale = 6'd8; PAR_EN = 1'b0; t0 = cyc;
    RX_IN = 1'b0;
    repeat (3) @(posedge clk); #1;
    RX_IN = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t4_state_c7", {29'd0, dut.state_r}, 32'd1);
    @(negedge clk);
    chk("t4_state_c8", {29'd0, dut.state_r}, 32'd0);
    @(posedge clk); #1;
    idle(4);
    chk("t4_no_strobe", dv_t.size() + pe_t.size() + se_t.size(), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 8); idle(6);
    chk("t4_pdata", {24'd0, P_DATA}, 32'h3C);
    chk("t4_dv_cnt", dv_t.size(), 32'd1);

    // P=32, bad stop bit
    clear_q(); Prescale = 6'd32; t0 = cyc;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 32); idle(40);
    chk("t5_se_cnt", se_t.size(), 32'd1);
    if (se_t.size() > 0) chk("t5_se_cyc", se_t[0] - t0, 32'd320);
    chk("t5_dv_cnt", dv_t.size(), 32'd0);
    chk("t5_pe_cnt", pe_t.size(), 32'd0);
    chk("t5_pdata", {24'd0, P_DATA}, 32'h3C);

    // back-to-back frames at P=16
    clear_q(); Prescale = 6'd16; t0 = cyc;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 16);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 16); idle(6);
    chk("t6_dv_cnt", dv_t.size(), 32'd2);
    if (dv_t.size() > 1) begin
      chk("t6_dv0_cyc", dv_t[0] - t0, 32'd160);
      chk("t6_dv1_cyc", dv_t[1] - t0, 32'd320);
      chk("t6_dv0_data", {24'd0, dv_d[0]}, 32'h00);
      chk("t6_dv1_data", {24'd0, dv_d[1]}, 32'hFF);
    end
    chk("t6_pdata", {24'd0, P_DATA}, 32'hFF);

    // reset at cycle 40 of a P=8 frame
    clear_q(); Prescale = 6'd8; t0 = cyc;
    send_bits({3'b111, 1'b1, 8'h5A}, 5, 8);
    RST = 1'b0; #1;
    chk("t7_rst_pdata", {24'd0, P_DATA}, 32'h00);
    chk("t7_rst_state", {29'd0, dut.state_r}, 32'd0);
    RX_IN = 1'b1;
    repeat (3) @(posedge clk); #1;
    RST = 1'b1;
    idle(80);
    chk("t7_no_strobe", dv_t.size() + pe_t.size() + se_t.size(), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8); idle(6);
    chk("t7_pdata", {24'd0, P_DATA}, 32'h5A);
    chk("t7_dv_cnt", dv_t.size(), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
